// File: rtl/bw_pkg.sv
// Shared types and helpers for the sequential Baugh-Wooley multiplier.
// Holds the FSM state encoding and the accumulator preload constant.
package bw_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } bw_state_t;

    // Widest operand the preload helper has to cover.
    localparam int BW_MAX_BITS = 64;

    // Baugh-Wooley correction constant: 2^numBit + 2^(2*numBit-1) for signed
    // operands, nothing for unsigned ones. The caller truncates to 2*numBit.
    function automatic logic [2*BW_MAX_BITS-1:0] bw_preload(input int num_bit,
                                                            input logic signed_mode);
        logic [2*BW_MAX_BITS-1:0] value;
        value = '0;
        if (signed_mode) begin
            value[num_bit]       = 1'b1;
            value[2*num_bit - 1] = 1'b1;
        end
        return value;
    endfunction

endpackage

// File: rtl/bw_row_gen.sv
// Combinational Baugh-Wooley partial-product row generator.
// Produces one row n[row_idx]*m, with the signed-mode inversions applied,
// already shifted left by its row index into a 2*numBit-bit word.
module bw_row_gen #(
    parameter int numBit = 16
) (
    input  logic [$clog2(numBit)-1:0] row_idx,
    input  logic [numBit-1:0]         m,
    input  logic [numBit-1:0]         n,
    input  logic                      signed_mode,
    output logic [2*numBit-1:0]       row
);

    localparam int IW = $clog2(numBit);

    logic              n_bit;
    logic [numBit-1:0] pp;

    assign n_bit = n[row_idx];

    // Form the unshifted row; in signed mode a bit is inverted when exactly one
    // of "last row" and "last column" holds (the NAND terms of Baugh-Wooley).
    always_comb begin
        pp = '0;
        for (int j = 0; j < numBit; j++) begin
            pp[j] = n_bit & m[j];
            if (signed_mode && ((row_idx == IW'(numBit - 1)) != (j == numBit - 1))) begin
                pp[j] = ~pp[j];
            end
        end
    end

    assign row = {{numBit{1'b0}}, pp} << row_idx;

endmodule

// File: rtl/bw_multiplier_seq.sv
// Sequential Baugh-Wooley multiplier: IDLE -> CALC -> DONE handshake FSM that
// reduces rowsPerCycle partial-product rows per clock into an accumulator.
// Optional feature macro BW_SIGN_MODE_EN adds a sign_in port selecting
// signed (1) or unsigned (0) operands; without it the block is always signed.
module bw_multiplier_seq
    import bw_pkg::*;
#(
    parameter int numBit       = 16,
    parameter int rowsPerCycle = 1
) (
    input  logic                clk_in,
    input  logic                rst_in,
`ifdef BW_SIGN_MODE_EN
    input  logic                sign_in,
`endif
    input  logic                valid_in,
    output logic                ready_out,
    input  logic [numBit-1:0]   m_in,
    input  logic [numBit-1:0]   n_in,
    output logic                valid_out,
    input  logic                ready_in,
    output logic [2*numBit-1:0] o_out,
    output logic                busy_out
);

    localparam int L  = numBit / rowsPerCycle;
    localparam int CW = $clog2(L) + 1;
    localparam int IW = $clog2(numBit);
    localparam int PW = 2 * numBit;

    bw_state_t         state;
    bw_state_t         state_next;
    logic [numBit-1:0] m_reg;
    logic [numBit-1:0] n_reg;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     acc_next;
    logic [PW-1:0]     o_reg;
    logic [PW-1:0]     preload;
    logic [CW-1:0]     row_cnt;
    logic              last_row_cycle;
    logic              sign_accept;
    logic              sign_mode;
    logic [PW-1:0]     rows    [rowsPerCycle];
    logic [IW-1:0]     row_idx [rowsPerCycle];

`ifdef BW_SIGN_MODE_EN
    logic sign_reg;

    // Latch the operand sign mode together with the operands.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sign_reg <= 1'b0;
        end else if (state == IDLE && valid_in) begin
            sign_reg <= sign_in;
        end
    end

    assign sign_accept = sign_in;
    assign sign_mode   = sign_reg;
`else
    assign sign_accept = 1'b1;
    assign sign_mode   = 1'b1;
`endif

    assign preload        = PW'(bw_preload(numBit, sign_accept));
    assign last_row_cycle = (row_cnt == CW'(L - 1));
    assign o_out          = o_reg;

    // State register; reset wins over every handshake input.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of process ordering.
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs decoded from the current state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can
        // leave one unassigned and infer a latch.
        state_next = state;
        ready_out  = 1'b0;
        valid_out  = 1'b0;
        busy_out   = 1'b0;
        unique case (state)
            IDLE: begin
                ready_out = 1'b1;
                if (valid_in) state_next = CALC;
            end
            CALC: begin
                busy_out = 1'b1;
                if (last_row_cycle) state_next = DONE;
            end
            DONE: begin
                valid_out = 1'b1;
                if (ready_in) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One row generator per row reduced in a cycle; row index = cnt*R + k.
    for (genvar k = 0; k < rowsPerCycle; k++) begin : g_rows
        assign row_idx[k] = IW'(int'(row_cnt) * rowsPerCycle + k);

        bw_row_gen #(.numBit(numBit)) u_row_gen (
            .row_idx     (row_idx[k]),
            .m           (m_reg),
            .n           (n_reg),
            .signed_mode (sign_mode),
            .row         (rows[k])
        );
    end

    // Sum this cycle's rows into the accumulator, modulo 2^(2*numBit).
    always_comb begin
        acc_next = acc;
        for (int k = 0; k < rowsPerCycle; k++) begin
            acc_next = acc_next + rows[k];
        end
    end

    // Operand capture, accumulation and result register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: the datapath is cleared too, so an aborted product can never
            // resurface on o_out after reset.
            m_reg   <= '0;
            n_reg   <= '0;
            acc     <= '0;
            o_reg   <= '0;
            row_cnt <= '0;
        end else if (state == IDLE && valid_in) begin
            m_reg   <= m_in;
            n_reg   <= n_in;
            acc     <= preload;
            row_cnt <= '0;
        end else if (state == CALC) begin
            acc     <= acc_next;
            row_cnt <= row_cnt + CW'(1);
            if (last_row_cycle) o_reg <= acc_next;
        end
    end

endmodule

// File: tb/tb_bw_multiplier_seq.sv
// Self-checking bench for bw_multiplier_seq: a rowsPerCycle=1 and a
// rowsPerCycle=4 instance share stimulus and are checked against an
// arithmetic product model.
module tb_bw_multiplier_seq;

    localparam int NB = 16;
    localparam int L1 = 16;
    localparam int L4 = 4;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          valid_in;
    logic          ready_in;
    logic          sign_in;
    logic [NB-1:0] m_in;
    logic [NB-1:0] n_in;

    logic            ready_out, valid_out, busy_out;
    logic [2*NB-1:0] o_out;
    logic            ready_out4, valid_out4, busy_out4;
    logic [2*NB-1:0] o_out4;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk_in = ~clk_in;

    bw_multiplier_seq #(.numBit(NB), .rowsPerCycle(1)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
`ifdef BW_SIGN_MODE_EN
        .sign_in   (sign_in),
`endif
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .m_in      (m_in),
        .n_in      (n_in),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .o_out     (o_out),
        .busy_out  (busy_out)
    );

    bw_multiplier_seq #(.numBit(NB), .rowsPerCycle(4)) dut4 (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
`ifdef BW_SIGN_MODE_EN
        .sign_in   (sign_in),
`endif
        .valid_in  (valid_in),
        .ready_out (ready_out4),
        .m_in      (m_in),
        .n_in      (n_in),
        .valid_out (valid_out4),
        .ready_in  (ready_in),
        .o_out     (o_out4),
        .busy_out  (busy_out4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sign mode actually in effect for a requested mode.
    function automatic logic eff_sign(input logic s);
`ifdef BW_SIGN_MODE_EN
        return s;
`else
        return 1'b1 | s;
`endif
    endfunction

    // Reference: plain integer multiplication, truncated to 2*NB bits.
    function automatic logic [2*NB-1:0] ref_product(input logic [NB-1:0] a,
                                                    input logic [NB-1:0] b,
                                                    input logic s);
        longint pa, pb;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'(a);
            pb = longint'(b);
        end
        return (2*NB)'(pa * pb);
    endfunction

    // Accept one operation, scramble the inputs, time both results, optionally
    // hold DONE under backpressure with fresh valid pulses, then release.
    task automatic run_op(input logic [NB-1:0] a, input logic [NB-1:0] b,
                          input logic s, input int hold_cycles, input string tag);
        int cyc  = 0;
        int lat1 = -1;
        int lat4 = -1;
        logic [2*NB-1:0] exp;
        exp = ref_product(a, b, eff_sign(s));
        check({tag, " ready_before"}, ready_out, 1);
        m_in = a; n_in = b; sign_in = s; valid_in = 1'b1; ready_in = 1'b0;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        m_in = NB'($urandom); n_in = NB'($urandom); sign_in = 1'($urandom);
        check({tag, " busy"}, busy_out, 1);
        while (lat1 < 0 && cyc < 40) begin
            @(posedge clk_in); #1;
            cyc++;
            if (valid_out4 && lat4 < 0) lat4 = cyc;
            if (valid_out && lat1 < 0) lat1 = cyc;
        end
        check({tag, " latency1"}, 64'(lat1), 64'(L1));
        check({tag, " latency4"}, 64'(lat4), 64'(L4));
        check({tag, " o_out"}, o_out, exp);
        check({tag, " o_out4"}, o_out4, exp);
        for (int i = 0; i < hold_cycles; i++) begin
            valid_in = 1'($urandom);
            m_in = NB'($urandom); n_in = NB'($urandom);
            @(posedge clk_in); #1;
            check({tag, " hold o_out"}, o_out, exp);
            check({tag, " hold ready"}, ready_out, 0);
            check({tag, " hold valid"}, valid_out, 1);
            check({tag, " hold busy"}, busy_out, 0);
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(posedge clk_in); #1;
        ready_in = 1'b0;
        check({tag, " ready_after"}, ready_out, 1);
        check({tag, " valid_after"}, valid_out, 0);
        check({tag, " ready4_after"}, ready_out4, 1);
    endtask

    initial begin
        int valid_seen;
        logic [NB-1:0] ra, rb;

        rst_in = 1'b1; valid_in = 1'b0; ready_in = 1'b0; sign_in = 1'b1;
        m_in = '0; n_in = '0;

        // Reset held for two edges.
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check("reset ready", ready_out, 1);
        check("reset valid", valid_out, 0);
        check("reset busy", busy_out, 0);
        check("reset o_out", o_out, 32'h0);
        check("reset o_out4", o_out4, 32'h0);

        // Directed corners.
        run_op(16'h8000, 16'h8000, 1'b1, 0, "min*min");
        check("min*min value", o_out, 32'h4000_0000);
        run_op(16'hFFFF, 16'h0003, 1'b1, 0, "neg1*3");
        check("neg1*3 value", o_out4, 32'hFFFF_FFFD);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 0, "ffff*ffff");
`ifdef BW_SIGN_MODE_EN
        check("unsigned value", o_out, 32'hFFFE_0001);
`endif
        run_op(16'h7FFF, 16'h8000, 1'b1, 0, "max*min");

        // Backpressure: five DONE cycles with new valid pulses.
        run_op(16'h1234, 16'hFEDC, 1'b1, 5, "backpressure");
        @(posedge clk_in); #1;
        check("no stray accept", busy_out, 0);

        // Reset during CALC at row 7.
        m_in = 16'h5A5A; n_in = 16'hA5A5; valid_in = 1'b1;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        repeat (7) @(posedge clk_in);
        #1;
        check("pre-abort busy", busy_out, 1);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        check("abort busy", busy_out, 0);
        check("abort ready", ready_out, 1);
        check("abort o_out", o_out, 32'h0);
        check("abort o_out4", o_out4, 32'h0);
        valid_seen = 0;
        repeat (30) begin
            @(posedge clk_in); #1;
            if (valid_out || valid_out4) valid_seen++;
        end
        check("abort no valid", 64'(valid_seen), 0);
        run_op(16'd3, 16'd5, 1'b1, 0, "3*5");
        check("3*5 value", o_out, 32'h0000_000F);

        // Randomized operations in both sign modes.
        for (int t = 0; t < 25; t++) begin
            ra = NB'($urandom);
            rb = NB'($urandom);
            run_op(ra, rb, 1'($urandom), (t % 5 == 0) ? 2 : 0, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/bw_multiplier_seq.md
BW_MULTIPLIER_SEQ -- requirements
Module: bw_multiplier_seq

Interface
REQ-001 SHALL have parameter numBit, default 16, meaning the operand width in bits (even, 4..64).
REQ-002 SHALL have parameter rowsPerCycle, default 1, meaning the partial-product rows reduced per clock; it must divide numBit.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk_in, input, 1 bit: the clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_in, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port valid_in, input, 1 bit: operands are valid.
REQ-007 SHALL have port ready_out, output, 1 bit: the block can accept operands.
REQ-008 SHALL have ports m_in and n_in, input, numBit bits each: the multiplicand and the multiplier.
REQ-009 SHALL have port valid_out, output, 1 bit: o_out holds a finished product.
REQ-010 SHALL have port ready_in, input, 1 bit: the downstream consumer accepts the product.
REQ-011 SHALL have port o_out, output, 2*numBit bits: the product.
REQ-012 SHALL have port busy_out, output, 1 bit: the block is in the CALC state.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-014 SHALL drive ready_out = (state == IDLE), valid_out = (state == DONE) and busy_out = (state == CALC).
REQ-015 SHALL, on the accept edge (IDLE with valid_in high):
  - capture m_in and n_in into internal registers;
  - clear the row counter;
  - preload the 2*numBit accumulator with the constant 2^numBit + 2^(2*numBit-1) in signed mode, or 0 in unsigned mode;
  - enter CALC.
REQ-016 SHALL, on each CALC edge, add rowsPerCycle Baugh-Wooley partial-product rows, each shifted left by its row index i, to the accumulator modulo 2^(2*numBit).
REQ-017 SHALL form signed rows as follows:
  - bits j<numBit-1 of rows i<numBit-1 = n[i] AND m[j];
  - bit numBit-1 of rows i<numBit-1 = NAND;
  - bits j<numBit-1 of row numBit-1 = NAND;
  - msb of row numBit-1 = AND.
REQ-018 SHALL form unsigned rows with AND only.
REQ-019 SHALL enter DONE on the L-th edge after the accept edge, where L = numBit/rowsPerCycle, with all rows accumulated and o_out equal to the exact product.
REQ-020 SHALL hold o_out, and ignore m_in, n_in and valid_in, while in DONE until the edge on which ready_in is high, then return to IDLE.
REQ-021 SHALL ignore valid_in outside IDLE; operand changes after the accept edge SHALL NOT affect the result.
REQ-022 SHALL NOT overlap operations; the minimum initiation interval is L+2 cycles when ready_in is held high.
REQ-023 SHALL update o_out only from the accumulator and keep it stable whenever valid_out is high.

Reset
REQ-024 SHALL, when rst_in is high on an edge, enter IDLE, clear o_out, the accumulator, the operand registers and the row counter to 0, and assert ready_out=1, valid_out=0 and busy_out=0 from the next cycle.
REQ-025 SHALL, on reset during CALC or DONE, abort the operation and discard its result; no valid_out pulse SHALL follow.
REQ-026 SHALL give reset priority over valid_in and ready_in on the same edge.

Configuration
REQ-027 SHALL add input port sign_in (1 bit; 1 = signed two's complement, 0 = unsigned), captured on the accept edge, when BW_SIGN_MODE_EN is defined.
REQ-028 SHALL omit sign_in when BW_SIGN_MODE_EN is undefined and always operate in signed Baugh-Wooley mode.

Structure
REQ-029 SHALL place the FSM state enum typedef and the preload-constant function of (numBit, signed) in shared package bw_pkg.
REQ-030 SHALL implement the combinational partial-product row generator (inputs: row index, operands, sign mode; output: one 2*numBit-bit shifted row) in sub-module bw_row_gen, instantiated rowsPerCycle times.
REQ-031 SHALL register the row counter at width $clog2(L)+1 and wrap it only through the IDLE preload.

Verification (numBit=16, rowsPerCycle=1 unless stated)
REQ-032 SHALL cover reset: rst_in high for 2 cycles -> ready_out=1, valid_out=0, busy_out=0, o_out=32'h0.
REQ-033 SHALL cover signed corner: m_in=16'h8000, n_in=16'h8000 accepted -> valid_out rises 16 edges later with o_out=32'h4000_0000.
REQ-034 SHALL cover mixed sign: m_in=16'hFFFF, n_in=16'h0003 -> o_out=32'hFFFF_FFFD; with rowsPerCycle=4 -> same value after 4 edges.
REQ-035 SHALL cover unsigned mode (BW_SIGN_MODE_EN defined, sign_in=0): m_in=n_in=16'hFFFF -> o_out=32'hFFFE_0001.
REQ-036 SHALL cover backpressure: ready_in low for 5 cycles in DONE while valid_in pulses with new operands -> o_out held, ready_out=0, no new accept; ready_in high -> IDLE, ready_out=1 the next cycle.
REQ-037 SHALL cover mid-operation reset: rst_in asserted at CALC row 7 -> busy_out=0 the next cycle, no valid_out ever, and a following 3*5 operation yields o_out=32'h0000_000F.
